// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - pipelined carry-lookahead add/subtract with valid/ready handshakes
module cla_adder_pipe #(
  parameter int N_BIT  = 16,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BIT-1:0] x,
  input  logic [N_BIT-1:0] y,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N_BIT-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int W  = N_BIT / STAGES;
  localparam int NG = W / BLOCK;

  // Per-stage state: operands are shifted down so the next slice always sits at [W-1:0],
  // while finished low slices accumulate in sum_q at their final bit positions.
  logic             v_q     [STAGES];
  logic             carry_q [STAGES];
  logic             msb_q   [STAGES];
  logic [N_BIT-1:0] a_q     [STAGES];
  logic [N_BIT-1:0] b_q     [STAGES];
  logic [N_BIT-1:0] sum_q   [STAGES];
  logic             v_d     [STAGES];
  logic             carry_d [STAGES];
  logic             msb_d   [STAGES];
  logic [N_BIT-1:0] a_d     [STAGES];
  logic [N_BIT-1:0] b_d     [STAGES];
  logic [N_BIT-1:0] sum_d   [STAGES];

  logic             adv;
  logic [N_BIT-1:0] b_eff;
  logic [W+1:0]     res_c;

  // Returns {carry out, carry into slice MSB, slice sum}.
  function automatic logic [W+1:0] cla_slice(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic         c0);
    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [W:0]    c;
    logic [NG-1:0] gg;
    logic [NG-1:0] pg;
    logic [NG:0]   cg;
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    gg    = '0;
    pg    = '0;
    cg    = '0;
    cg[0] = c0;
    for (int k = 0; k < NG; k++) begin
      gg[k] = 1'b0;
      pg[k] = 1'b1;
      for (int j = 0; j < BLOCK; j++) begin
        gg[k] = g[k*BLOCK+j] | (p[k*BLOCK+j] & gg[k]);
        pg[k] = pg[k] & p[k*BLOCK+j];
      end
      cg[k+1] = gg[k] | (pg[k] & cg[k]);
    end
    for (int k = 0; k < NG; k++) begin
      c[k*BLOCK] = cg[k];
      for (int j = 1; j < BLOCK; j++) begin
        c[k*BLOCK+j] = g[k*BLOCK+j-1] | (p[k*BLOCK+j-1] & c[k*BLOCK+j-1]);
      end
    end
    c[W] = cg[NG];
    return {c[W], c[W-1], p ^ c[W-1:0]};
  endfunction

  assign adv      = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      v_d[s]     = 1'b0;
      carry_d[s] = 1'b0;
      msb_d[s]   = 1'b0;
      a_d[s]     = '0;
      b_d[s]     = '0;
      sum_d[s]   = '0;
    end
    b_eff = sub ? ~y : y;
    res_c = cla_slice(x[W-1:0], b_eff[W-1:0], cin ^ sub);
    v_d[0]          = in_valid;
    carry_d[0]      = res_c[W+1];
    msb_d[0]        = res_c[W];
    a_d[0]          = x >> W;
    b_d[0]          = b_eff >> W;
    sum_d[0][W-1:0] = res_c[W-1:0];
    for (int s = 1; s < STAGES; s++) begin
      res_c = cla_slice(a_q[s-1][W-1:0], b_q[s-1][W-1:0], carry_q[s-1]);
      v_d[s]            = v_q[s-1];
      carry_d[s]        = res_c[W+1];
      msb_d[s]          = res_c[W];
      a_d[s]            = a_q[s-1] >> W;
      b_d[s]            = b_q[s-1] >> W;
      sum_d[s]          = sum_q[s-1];
      sum_d[s][s*W +: W] = res_c[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]     <= 1'b0;
        carry_q[s] <= 1'b0;
        msb_q[s]   <= 1'b0;
        a_q[s]     <= '0;
        b_q[s]     <= '0;
        sum_q[s]   <= '0;
      end
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]     <= v_d[s];
        carry_q[s] <= carry_d[s];
        msb_q[s]   <= msb_d[s];
        a_q[s]     <= a_d[s];
        b_q[s]     <= b_d[s];
        sum_q[s]   <= sum_d[s];
      end
    end
  end

  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = carry_q[STAGES-1] ^ msb_q[STAGES-1];
  assign out_valid = v_q[STAGES-1];

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - directed and random self-checking bench for cla_adder_pipe
module tb_cla_adder_pipe;

  localparam int N_BIT  = 16;
  localparam int STAGES = 2;
  localparam int BLOCK  = 4;

  typedef logic [N_BIT+1:0] res_t;
  typedef struct {
    logic [N_BIT-1:0] a;
    logic [N_BIT-1:0] b;
    logic             c;
    logic             s;
    logic [N_BIT-1:0] es;
    logic             ec;
    logic             eo;
  } lit_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_BIT-1:0] x = '0;
  logic [N_BIT-1:0] y = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N_BIT-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;
  logic             out_ready = 1'b1;

  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  res_t exp_q[$];
  bit   hold_p = 1'b0;
  res_t snap;

  always #5 clk = ~clk;

  cla_adder_pipe #(.N_BIT(N_BIT), .STAGES(STAGES), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .cin(cin), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [N_BIT-1:0] a, input logic [N_BIT-1:0] b,
                                 input logic c, input logic s);
    logic [N_BIT-1:0] be;
    logic [N_BIT:0]   f;
    logic             o;
    be = s ? ~b : b;
    f  = {1'b0, a} + {1'b0, be} + {{N_BIT{1'b0}}, c ^ s};
    o  = (a[N_BIT-1] == be[N_BIT-1]) && (f[N_BIT-1] != a[N_BIT-1]);
    return {o, f[N_BIT], f[N_BIT-1:0]};
  endfunction

  // Scoreboard: inputs change at posedge+1, so pre-edge handshake values are seen here.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(x, y, cin, sub));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) check("stall_hold", {out_valid, ovf, cout, sum}, {1'b1, snap});
      if (out_valid) begin
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("model_out", {ovf, cout, sum}, exp_q[0]);
      end
      hold_p = out_valid && !out_ready;
      if (hold_p) begin
        snap = {ovf, cout, sum};
        check("stall_in_ready", in_ready, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input lit_t v, input string nm);
    x = v.a; y = v.b; cin = v.c; sub = v.s; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({nm, "_early"}, out_valid, 0);
    repeat (STAGES - 1) step();
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_sum"}, sum, v.es);
    check({nm, "_cout"}, cout, v.ec);
    check({nm, "_ovf"}, ovf, v.eo);
    step();
  endtask

  lit_t lits [9] = '{
    '{16'h0004, 16'h0001, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0},
    '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0},
    '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h0044, 16'h0029, 1'b1, 1'b1, 16'h001A, 1'b1, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0}
  };

  lit_t bp [6] = '{
    '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0},
    '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0},
    '{16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0},
    '{16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0},
    '{16'hABCD, 16'h1111, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0}
  };

  initial begin
    int   i;
    int   cyc;
    int   p0;
    logic acc;

    rst_n = 1'b0;
    repeat (3) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);

    for (int k = 0; k < 9; k++) lit(lits[k], $sformatf("lit%0d", k));

    p0 = pops; i = 0; cyc = 0;
    while (i < 6 && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      in_valid = 1'b1;
      x = bp[i].a; y = bp[i].b; cin = bp[i].c; sub = bp[i].s;
      @(negedge clk);
      acc = in_ready;
      if (cyc == 4) check("bp_stall_in_ready", in_ready, 0);
      step();
      if (acc) i++;
      cyc++;
    end
    check("bp_accepted", i, 6);
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin step(); cyc++; end
    check("bp_results", pops - p0, 6);
    check("bp_drained", exp_q.size(), 0);

    out_ready = 1'b1; in_valid = 1'b1;
    x = 16'h0102; y = 16'h0304; cin = 1'b0; sub = 1'b0;
    step();
    x = 16'h1111; y = 16'h2222;
    step();
    rst_n = 1'b0;
    step();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout_ovf", {cout, ovf}, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("midrst_no_stale", out_valid, 0);
    end

    for (int k = 0; k < 300; k++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      x   = N_BIT'($urandom);
      y   = N_BIT'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin step(); cyc++; end
    check("rand_drained", exp_q.size(), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
